// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state type and limits for the display source scheduler
package display_pkg;

  localparam int DISPLAY_DATA_W  = 32;
  localparam int MAX_DISPLAY_SRC = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HOLD = 2'd2
  } disp_state_t;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchronizer, stability counter and rising-edge pulse for a push-button
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples; pulse on accepted rise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_rise  <= 1'b0;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync1;
        r_rise  <= r_sync1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/display_source_scheduler.sv
// rtl/display_source_scheduler.sv - shares the 7-segment display between NUM_SRC taps; DISPLAY_AUTO_SCAN_EN adds the dwell timer
module display_source_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [32*NUM_SRC-1:0]      src_data,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic                       btn_next,
  input  logic                       freeze,
  output logic [DISPLAY_DATA_W-1:0]  data_to_display,
  output logic [$clog2(NUM_SRC)-1:0] src_sel,
  output logic                       blank,
  output logic                       advance
);
  localparam int SEL_W = $clog2(NUM_SRC);

  disp_state_t               r_state;
  disp_state_t               w_next_state;
  logic [SEL_W-1:0]          r_src_sel;
  logic [SEL_W-1:0]          w_next_sel;
  logic [DISPLAY_DATA_W-1:0] r_data;
  logic [DISPLAY_DATA_W-1:0] w_cur_word;
  logic [DISPLAY_DATA_W-1:0] w_next_word;
  logic                      r_blank;
  logic                      r_advance;
  logic                      w_btn_rise;
  logic                      w_expire;
  logic                      w_any_valid;
  logic                      w_step;
  logic                      w_sel_change;

  // Nearest valid index above cur, wrapping; cur itself is the last candidate
  function automatic logic [SEL_W-1:0] next_valid(input logic [NUM_SRC-1:0] valid,
                                                 input logic [SEL_W-1:0]   cur);
    logic [SEL_W-1:0] idx;
    next_valid = cur;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      idx = SEL_W'((int'(cur) + k) % NUM_SRC);
      if (valid[idx]) next_valid = idx;
    end
  endfunction

  function automatic logic [SEL_W-1:0] first_valid(input logic [NUM_SRC-1:0] valid);
    first_valid = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (valid[k]) first_valid = SEL_W'(k);
    end
  endfunction

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst   (rst),
    .i_btn (btn_next),
    .o_rise(w_btn_rise)
  );

  assign w_any_valid  = |src_valid;
  assign w_cur_word   = src_data[DISPLAY_DATA_W*int'(r_src_sel) +: DISPLAY_DATA_W];
  assign w_next_word  = src_data[DISPLAY_DATA_W*int'(w_next_sel) +: DISPLAY_DATA_W];
  assign w_sel_change = (w_next_state != IDLE) && (w_next_sel != r_src_sel);

`ifdef DISPLAY_AUTO_SCAN_EN
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

  logic [DWELL_W-1:0] r_dwell;

  assign w_expire = (r_state == SHOW) && (r_dwell == DWELL_W'(DWELL_CYCLES - 1));

  // Dwell timer: runs only while live, restarts on any source change, expiry or entry to SHOW
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell <= '0;
    end else if (w_sel_change || w_expire || (r_state != SHOW && w_next_state == SHOW)) begin
      r_dwell <= '0;
    end else if (r_state == SHOW) begin
      r_dwell <= r_dwell + 1'b1;
    end
  end
`else
  // Timer removed: the dwell length is accepted but can never expire
  assign w_expire = (DWELL_CYCLES < 0);
`endif

  // Next state and next selection; any step source (button, dwell, lost source) yields one move
  always_comb begin
    w_next_state = r_state;
    w_next_sel   = r_src_sel;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_next_sel   = first_valid(src_valid);
          w_next_state = freeze ? HOLD : SHOW;
        end
      end
      SHOW, HOLD: begin
        if (!w_any_valid) begin
          w_next_state = IDLE;
        end else begin
          w_step = w_btn_rise || w_expire || !src_valid[r_src_sel];
          if (w_step) w_next_sel = next_valid(src_valid, r_src_sel);
          w_next_state = freeze ? HOLD : SHOW;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Selection, shown value and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_sel <= '0;
      r_data    <= '0;
      r_blank   <= 1'b1;
      r_advance <= 1'b0;
    end else begin
      r_src_sel <= w_next_sel;
      r_advance <= w_sel_change;
      r_blank   <= (w_next_state == IDLE);
      if (w_next_state == IDLE) begin
        r_data <= '0;
      end else if (r_state == IDLE) begin
        r_data <= w_next_word;
      end else if (r_state == SHOW || r_advance) begin
        // HOLD refreshes once, the cycle after a step, to snapshot the new source
        r_data <= w_cur_word;
      end
    end
  end

  assign data_to_display = r_data;
  assign src_sel         = r_src_sel;
  assign blank           = r_blank;
  assign advance         = r_advance;

endmodule

// File: tb/tb_display_source_scheduler.sv
// tb/tb_display_source_scheduler.sv - randomized bench with behavioural model for display_source_scheduler
module tb_display_source_scheduler;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int DEB = 4;
`ifdef DISPLAY_AUTO_SCAN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] src_data;
  logic [3:0]   src_valid;
  logic         btn_next;
  logic         freeze;
  logic [31:0]  data_to_display;
  logic [1:0]   src_sel;
  logic         blank;
  logic         advance;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  display_source_scheduler #(
    .NUM_SRC(N), .DWELL_CYCLES(DW), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .btn_next(btn_next), .freeze(freeze), .data_to_display(data_to_display),
    .src_sel(src_sel), .blank(blank), .advance(advance)
  );

  always #5 clk = ~clk;

  // st: 0 = no source shown, 1 = live, 2 = frozen
  typedef struct packed {
    int          st;
    int          sel;
    int          dwell;
    logic [31:0] data;
    bit          blank;
    bit          adv;
    bit          h1;
    bit          h2;
    bit          level;
    int          run;
    bit          rise;
  } model_t;

  model_t m;

  function automatic model_t mstep(model_t o, logic r, logic [3:0] v, logic [127:0] d,
                                   logic btn, logic frz);
    model_t n;
    bit expire;
    int low;
    n = o;
    if (r) begin
      n = '0;
      n.blank = 1'b1;
      return n;
    end
    // button: seen two samples late, accepted after DEB differing samples in a row
    n.h1 = btn;
    n.h2 = o.h1;
    n.rise = 1'b0;
    if (o.h2 != o.level) begin
      n.run = o.run + 1;
      if (n.run == DEB) begin
        n.level = o.h2;
        n.rise  = o.h2;
        n.run   = 0;
      end
    end else begin
      n.run = 0;
    end
    n.adv  = 1'b0;
    expire = AUTO && (o.st == 1) && (o.dwell == DW - 1);
    if (o.st == 0) begin
      if (v != 4'd0) begin
        low = 0;
        while (!v[low]) low++;
        n.sel   = low;
        n.st    = frz ? 2 : 1;
        n.data  = d[low*32 +: 32];
        n.adv   = (low != o.sel);
        n.dwell = 0;
      end
    end else if (v == 4'd0) begin
      n.st   = 0;
      n.data = 32'd0;
    end else begin
      if (o.rise || expire || !v[o.sel]) begin
        for (int k = 1; k <= N; k++) begin
          if (v[(o.sel + k) % N]) begin
            n.sel = (o.sel + k) % N;
            break;
          end
        end
      end
      n.adv = (n.sel != o.sel);
      n.st  = frz ? 2 : 1;
      if (o.st == 1 || o.adv) n.data = d[o.sel*32 +: 32];
      if (o.st == 1) n.dwell = (n.adv || expire) ? 0 : o.dwell + 1;
      if (o.st != 1 && n.st == 1) n.dwell = 0;
    end
    n.blank = (n.st == 0);
    return n;
  endfunction

  always @(posedge clk) m <= mstep(m, rst, src_valid, src_data, btn_next, freeze);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // one clock; outputs sampled 1 time unit after the edge and compared with the model
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cmp_en) begin
      checks++;
      if (data_to_display !== m.data || src_sel !== 2'(m.sel) ||
          blank !== m.blank || advance !== m.adv) begin
        failures++;
        $display("FAIL model_cmp t=%0t data=%h/%h sel=%0d/%0d blank=%0b/%0b adv=%0b/%0b",
                 $time, data_to_display, m.data, src_sel, m.sel, blank, m.blank,
                 advance, m.adv);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic btn_window(input int pstart, input int plen, input int nc,
                            output int adv_cnt, output int first_adv);
    adv_cnt   = 0;
    first_adv = -1;
    for (int c = 0; c < nc; c++) begin
      btn_next = (c >= pstart && c < pstart + plen);
      cyc();
      if (advance) begin
        adv_cnt++;
        if (first_adv < 0) first_adv = c + 1;
      end
    end
    btn_next = 1'b0;
  endtask

  int nadv;
  int fadv;
  bit saw2;
  int btn_hold;

  initial begin
    rst       = 1'b1;
    src_data  = '0;
    src_valid = 4'b0000;
    btn_next  = 1'b0;
    freeze    = 1'b0;

    // reset state
    do_reset();
    cmp_en = 1'b1;
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_data", data_to_display, 32'd0);
    chk("rst_sel", 32'(src_sel), 32'd0);
    chk("rst_adv", 32'(advance), 32'd0);
    cyc();
    cyc();
    chk("idle_blank", 32'(blank), 32'd1);
    src_valid = 4'b1111;
    src_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h12345678};
    cyc();
    chk("show_data", data_to_display, 32'h12345678);
    chk("show_blank", 32'(blank), 32'd0);
    chk("model_show_data", m.data, 32'h12345678);

    // auto-scan with index 2 invalid
    src_valid = 4'b1011;
    do_reset();
    nadv = 0;
    saw2 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      cyc();
      if (advance) nadv++;
      if (src_sel == 2'd2) saw2 = 1'b1;
      if (c == 9)  chk("scan_sel_9", 32'(src_sel), AUTO ? 32'd1 : 32'd0);
      if (c == 17) chk("scan_sel_17", 32'(src_sel), AUTO ? 32'd3 : 32'd0);
      if (c == 25) chk("scan_sel_25", 32'(src_sel), 32'd0);
    end
    chk("scan_adv_count", 32'(nadv), AUTO ? 32'd3 : 32'd0);
    chk("scan_never_2", 32'(saw2), 32'd0);

    // button glitch, then a clean press
    src_valid = 4'b1111;
    do_reset();
    btn_window(0, 2, 8, nadv, fadv);
    chk("glitch_no_adv", 32'(nadv), 32'd0);
    do_reset();
    btn_window(0, 10, 12, nadv, fadv);
    chk("press_one_adv", 32'(nadv), 32'd1);
    chk("press_latency", 32'(fadv), 32'd7);

    // button edge landing on the dwell expiry edge
    do_reset();
    btn_window(2, 6, 12, nadv, fadv);
    chk("coinc_one_adv", 32'(nadv), 32'd1);
    chk("coinc_at_9", 32'(fadv), 32'd9);
    chk("coinc_sel", 32'(src_sel), 32'd1);

    // freeze, then step while frozen
    src_data = {32'h44444444, 32'h33333333, 32'h11111111, 32'hAAAA0000};
    do_reset();
    cyc();
    chk("freeze_pre", data_to_display, 32'hAAAA0000);
    freeze = 1'b1;
    cyc();
    src_data[31:0] = 32'h5555FFFF;
    cyc();
    cyc();
    cyc();
    chk("freeze_hold", data_to_display, 32'hAAAA0000);
    btn_window(0, 6, 10, nadv, fadv);
    chk("hold_step_adv", 32'(fadv), 32'd7);
    chk("hold_step_snapshot", data_to_display, 32'h11111111);
    src_data[63:32] = 32'h22222222;
    cyc();
    cyc();
    cyc();
    chk("hold_after_snapshot", data_to_display, 32'h11111111);
    chk("hold_sel", 32'(src_sel), 32'd1);
    freeze = 1'b0;

    // selected source disappears, then all sources
    do_reset();
    cyc();
    src_valid = 4'b1110;
    cyc();
    chk("drop_sel", 32'(src_sel), 32'd1);
    chk("drop_adv", 32'(advance), 32'd1);
    chk("model_drop_sel", 32'(m.sel), 32'd1);
    src_valid = 4'b0000;
    cyc();
    chk("drop_all_blank", 32'(blank), 32'd1);
    chk("drop_all_data", data_to_display, 32'd0);
    chk("drop_all_sel", 32'(src_sel), 32'd1);

    // reset in the middle of debouncing discards the press
    src_valid = 4'b1111;
    do_reset();
    btn_window(0, 3, 3, nadv, fadv);
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    btn_window(0, 0, 8, nadv, fadv);
    chk("rst_mid_debounce", 32'(nadv), 32'd0);

    // randomized traffic checked every cycle against the model
    do_reset();
    btn_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) src_valid = 4'($urandom);
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 3) == 0) src_data[s*32 +: 32] = $urandom;
      end
      if (btn_hold == 0) begin
        btn_next = 1'($urandom_range(0, 1));
        btn_hold = $urandom_range(1, 12);
      end else begin
        btn_hold--;
      end
      if ($urandom_range(0, 31) == 0) freeze = ~freeze;
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
